uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8: clk cycles per serial bit; legal values are even integers from 4 to 255.
REQ-002 clk  input  1  single clock; all logic is on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-005 data_byte  output  8  last correctly framed received byte.
REQ-006 data_valid  output  1  one-cycle pulse; data_byte is new this cycle.
REQ-007 framing_err  output  1  one-cycle pulse; stop bit was sampled low.
REQ-008 lineactive  output  1  high while a frame is being received.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-010 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); there is no parity.
REQ-011 The FSM SHALL have states IDLE, START_BIT, DATA_BITS, STOP_BIT and CLEANUP; unused encodings SHALL go to IDLE.
REQ-012 IDLE: counter=0, bit index=0, lineactive=0; when rx_s=0 (cycle t0), go to START_BIT.
REQ-013 START_BIT: count CLKS_PER_BIT/2 cycles from t0, then sample rx_s (mid start bit).
- If rx_s=0, reset the counter, set lineactive=1 and go to DATA_BITS.
- If rx_s=1, treat it as a glitch and return to IDLE; no output pulses.
REQ-014 DATA_BITS: sample rx_s every CLKS_PER_BIT cycles after the mid-start sample, into shift register bit [index].
- index counts 0..7.
- After index 7 is sampled, go to STOP_BIT.
REQ-015 STOP_BIT: sample rx_s CLKS_PER_BIT cycles after data bit 7, i.e. at t0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
- If rx_s=1, load data_byte from the shift register and pulse data_valid on the next cycle.
- If rx_s=0, pulse framing_err on the next cycle; data_byte SHALL stay unchanged.
- In both cases lineactive=0 and the next state is CLEANUP.
REQ-016 CLEANUP SHALL last exactly one cycle, deassert the pulses and go to IDLE.
REQ-017 data_valid and framing_err SHALL never both be high, and each SHALL be high for exactly 1 cycle per frame.
REQ-018 data_byte SHALL hold its value until the next valid frame.
REQ-019 The counter SHALL be 8 bits wide, with no wrap within any state.
REQ-020 A new start bit SHALL be accepted on the first IDLE cycle after CLEANUP (back-to-back frames, no extra gap).
REQ-021 With CLKS_PER_BIT=8, data_valid SHALL be high at t0+77.

Reset
REQ-022 While rst_n=0, all of the following SHALL hold:
- state=IDLE, counters=0;
- data_byte=8'h00, data_valid=0, framing_err=0, lineactive=0;
- synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no pulse. After release, receiving SHALL resume only on the next falling edge, after rx_s has been 1 at least once.

Structure
REQ-024 The shared package uart_pkg SHALL hold:
- the state encodings (shared with the transmitter);
- the default CLKS_PER_BIT;
- the data width constant 8.
REQ-025 The synchronizer SHALL be a sub-module uart_sync2 (2 flops, reset value 1); the FSM, counter and shift register stay in uart_rx.

Verification
REQ-026 CLKS_PER_BIT=8, frame 0xA5 -> data_valid for 1 cycle at t0+77, data_byte=0xA5, framing_err=0.
REQ-027 Back-to-back 0x00 then 0xFF with no idle gap -> two data_valid pulses 80 cycles apart, bytes 0x00 then 0xFF.
REQ-028 rx low for 3 cycles, then high -> lineactive never 1, no pulses, FSM back in IDLE.
REQ-029 Frame 0x3C with stop bit forced 0 -> framing_err pulse, no data_valid, data_byte keeps its previous value.
REQ-030 rst_n low during data bit 4 of 0x5A, then frame 0x81 -> only 0x81 reported, data_valid exactly once.
REQ-031 Sweep CLKS_PER_BIT in {4,16}, random bytes -> every byte received correctly with the REQ-015 timing.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encodings shared by the UART receiver and
// transmitter.
//   CLKS_PER_BIT_DEF : default clk cycles per serial bit
//   DATA_W           : payload width of one frame
//   uart_state_e     : frame-level FSM state encoding
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 8;
  localparam int unsigned DATA_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_BIT = 3'd1,
    ST_DATA_BITS = 3'd2,
    ST_STOP_BIT  = 3'd3,
    ST_CLEANUP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so the line reads idle while and after reset.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronized output
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, mid-bit sampling.
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   rx          : serial line, idle high, asynchronous to clk
//   data_byte   : last correctly framed byte
//   data_valid  : one-cycle pulse, data_byte updated
//   framing_err : one-cycle pulse, stop bit sampled low
//   lineactive  : high while data/stop bits are being received
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_IDLE      | line idle, waiting for rx_s low
// ST_START_BIT | timing half a bit to the middle of the start bit
// ST_DATA_BITS | sampling 8 data bits, LSB first, one per bit period
// ST_STOP_BIT  | sampling the stop bit, reporting byte or framing error
// ST_CLEANUP   | single cycle that ends the output pulses
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] data_byte,
  output logic              data_valid,
  output logic              framing_err,
  output logic              lineactive
);

  localparam int unsigned IDX_W = $clog2(DATA_W);
  // Down-counter terminal loads: the counter hits zero on the sample cycle.
  localparam logic [7:0] HALF_TC = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] BIT_TC  = 8'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic rx_s;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  uart_state_e       state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_byte_q, data_byte_d;
  logic              data_valid_q, data_valid_d;
  logic              framing_err_q, framing_err_d;
  logic              lineactive_q, lineactive_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      data_byte_q   <= '0;
      data_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
      lineactive_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      data_byte_q   <= data_byte_d;
      data_valid_q  <= data_valid_d;
      framing_err_q <= framing_err_d;
      lineactive_q  <= lineactive_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    data_byte_d   = data_byte_q;
    data_valid_d  = 1'b0;
    framing_err_d = 1'b0;
    lineactive_d  = lineactive_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d        = '0;
        idx_d        = '0;
        lineactive_d = 1'b0;
        if (!rx_s) begin
          // The cycle that sees rx_s low counts as the first of the half bit.
          cnt_d   = HALF_TC;
          state_d = ST_START_BIT;
        end
      end

      ST_START_BIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!rx_s) begin
          cnt_d        = BIT_TC;
          lineactive_d = 1'b1;
          state_d      = ST_DATA_BITS;
        end else begin
          // Start bit gone by mid-bit: a glitch, drop it silently.
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      ST_DATA_BITS: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          shift_d[idx_q] = rx_s;
          cnt_d          = BIT_TC;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_STOP_BIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_STOP_BIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cnt_d        = '0;
          lineactive_d = 1'b0;
          state_d      = ST_CLEANUP;
          if (rx_s) begin
            data_byte_d  = shift_q;
            data_valid_d = 1'b1;
          end else begin
            framing_err_d = 1'b1;
          end
        end
      end

      ST_CLEANUP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d      = ST_IDLE;
        cnt_d        = '0;
        idx_d        = '0;
        lineactive_d = 1'b0;
      end
    endcase
  end

  assign data_byte   = data_byte_q;
  assign data_valid  = data_valid_q;
  assign framing_err = framing_err_q;
  assign lineactive  = lineactive_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: three receivers (8, 4 and 16 clks per bit) on a shared clock
// and reset. A frame-level model predicts, for each complete frame sent,
// the exact cycle of the result pulse, its kind and the data_byte value.
module tb_uart_rx;

  typedef struct {
    int         lane;
    int         cyc;
    bit         is_err;
    logic [7:0] b;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] rx_l;
  logic [7:0] db0, db1, db2;
  logic [2:0] dv, fe, la;

  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];
  logic [7:0] last_good [3];
  bit   la_seen [3];

  uart_rx #(.CLKS_PER_BIT(8)) u_rx8 (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .data_byte(db0),
    .data_valid(dv[0]), .framing_err(fe[0]), .lineactive(la[0]));

  uart_rx #(.CLKS_PER_BIT(4)) u_rx4 (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .data_byte(db1),
    .data_valid(dv[1]), .framing_err(fe[1]), .lineactive(la[1]));

  uart_rx #(.CLKS_PER_BIT(16)) u_rx16 (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[2]), .data_byte(db2),
    .data_valid(dv[2]), .framing_err(fe[2]), .lineactive(la[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cpb_of(input int lane);
    case (lane)
      0:       return 8;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  function automatic logic [7:0] db_of(input int lane);
    case (lane)
      0:       return db0;
      1:       return db1;
      default: return db2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge. Start bit goes out now; the receiver
  // reports 2 sync cycles + 1 detect cycle + half a bit + 9 bits later.
  task automatic send_frame(input int lane, input logic [7:0] b,
                            input logic stop_bit, input int nbits);
    int         cpb;
    logic [9:0] bits;
    exp_t       e;
    cpb  = cpb_of(lane);
    bits = {stop_bit, b, 1'b0};
    if (nbits == 10) begin
      e.lane   = lane;
      e.cyc    = cyc + 3 + cpb / 2 + 9 * cpb;
      e.is_err = !stop_bit;
      e.b      = stop_bit ? b : last_good[lane];
      exp_q.push_back(e);
      if (stop_bit) last_good[lane] = b;
    end
    for (int k = 0; k < nbits; k++) begin
      rx_l[lane] = bits[k];
      for (int c = 0; c < cpb; c++) begin
        @(posedge clk);
        #1;
        if (nbits == 10 && k == 5 && c == 0)
          chk("lineactive_mid", 32'(la[lane]), 32'd1);
      end
    end
    rx_l[lane] = 1'b1;
  endtask

  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (la[l]) la_seen[l] = 1'b1;
      if (dv[l] || fe[l]) begin
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (idx < 0 && exp_q[i].lane == l) idx = i;
        chk("pulse_exclusive", 32'(dv[l] & fe[l]), 32'd0);
        chk("lineactive_at_pulse", 32'(la[l]), 32'd0);
        if (idx < 0) begin
          chk("unexpected_pulse", 32'({dv[l], fe[l]}), 32'd0);
        end else begin
          chk("pulse_cycle", 32'(cyc), 32'(exp_q[idx].cyc));
          chk("pulse_kind", 32'({dv[l], fe[l]}), exp_q[idx].is_err ? 32'd1 : 32'd2);
          chk("data_byte", 32'(db_of(l)), 32'(exp_q[idx].b));
          exp_q.delete(idx);
        end
      end
    end
  end

  initial begin
    int         gap;
    logic [7:0] b;
    logic       s;
    n_cmp = 0;
    n_err = 0;
    for (int l = 0; l < 3; l++) begin
      last_good[l] = 8'h00;
      la_seen[l]   = 1'b0;
    end
    rst_n = 1'b0;
    rx_l  = 3'b111;
    idle(3);
    for (int l = 0; l < 3; l++) begin
      chk("reset_data_byte", 32'(db_of(l)), 32'd0);
      chk("reset_pulses", 32'({dv[l], fe[l]}), 32'd0);
      chk("reset_lineactive", 32'(la[l]), 32'd0);
    end
    rst_n = 1'b1;
    idle(5);

    // single frame, then back-to-back 0x00 / 0xFF
    send_frame(0, 8'hA5, 1'b1, 10);
    idle(16);
    send_frame(0, 8'h00, 1'b1, 10);
    send_frame(0, 8'hFF, 1'b1, 10);
    idle(24);

    // 3-cycle glitch must be ignored
    la_seen[0] = 1'b0;
    rx_l[0] = 1'b0;
    idle(3);
    rx_l[0] = 1'b1;
    idle(20);
    chk("glitch_lineactive", 32'(la_seen[0]), 32'd0);

    // framing error keeps previous byte
    send_frame(0, 8'h3C, 1'b0, 10);
    idle(24);

    // reset in the middle of data bit 4 of 0x5A
    send_frame(0, 8'h5A, 1'b1, 5);
    rx_l[0] = 1'b1;
    idle(4);
    rst_n = 1'b0;
    idle(2);
    chk("midreset_data_byte", 32'(db0), 32'd0);
    chk("midreset_pulses", 32'({dv[0], fe[0]}), 32'd0);
    chk("midreset_lineactive", 32'(la[0]), 32'd0);
    for (int l = 0; l < 3; l++) last_good[l] = 8'h00;
    rst_n = 1'b1;
    idle(10);
    send_frame(0, 8'h81, 1'b1, 10);
    idle(16);

    // random traffic with occasional bad stop bits
    for (int n = 0; n < 6; n++) begin
      b   = 8'($urandom_range(0, 255));
      s   = ($urandom_range(0, 3) != 0);
      gap = s ? $urandom_range(0, 2) : $urandom_range(2, 3);
      send_frame(0, b, s, 10);
      idle(gap * 8);
    end
    idle(16);

    // other bit rates
    for (int l = 1; l < 3; l++) begin
      for (int n = 0; n < 8; n++) begin
        b   = 8'($urandom_range(0, 255));
        gap = $urandom_range(0, 1);
        send_frame(l, b, 1'b1, 10);
        idle(gap * cpb_of(l));
      end
      idle(3 * cpb_of(l));
    end

    idle(40);
    chk("pending_frames", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
